// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
//   fetch_entry_t    : one buffered instruction word tagged with its byte address
//   INSTR_BYTES      : PC increment per sequential fetch
//   INSTR_ALIGN_BITS : low PC bits that are always zero for an aligned word
package instr_fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;

  localparam int INSTR_BYTES      = 4;
  localparam int INSTR_ALIGN_BITS = 2;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : drop all entries; wins over push and pop in the same cycle
//   push, push_data : write one entry at the tail (caller guarantees room)
//   pop             : retire the head entry (caller guarantees non-empty)
//   count           : number of stored entries, 0..DEPTH
//   head            : head entry, read combinationally from storage
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           storage [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed while count says so.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wptr] <= push_data;
  end

  assign head = storage[rptr];

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction fetch/prefetch stage.
// Owns the fetch PC, issues sequential word reads to a 1-cycle-latency SRAM
// port, buffers returned words with their byte addresses and hands them to
// decode.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   fetch_en_i     : allow new memory requests
//   branch_i       : single-cycle redirect strobe; branch_addr_i is the target
//   mem_req_o      : RAM read enable (never stalled by the RAM)
//   mem_addr_o     : RAM word address
//   mem_rdata_i    : RAM data, valid the cycle after mem_req_o
//   instr_valid_o  : head of the buffer is presentable
//   instr_ready_i  : decode takes the head this cycle
//   instr_rdata_o  : head instruction word
//   instr_addr_o   : head instruction byte address
//
// Handshake: a word transfers in every cycle where instr_valid_o and
// instr_ready_i are both high. instr_valid_o does not depend on
// instr_ready_i, and once raised it stays up until the transfer or a branch.
module instr_prefetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 32,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  MEM_ADDR_WIDTH = 14,
  parameter int                  FIFO_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR    = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en_i,
  input  logic                      branch_i,
  input  logic [ADDR_WIDTH-1:0]     branch_addr_i,
  output logic                      mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]     instr_addr_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  rvalid_q;

  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  // The two low target bits are dropped: fetches are always word aligned.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr_i[INSTR_ALIGN_BITS-1:0];

  // Room is reserved for the read already in flight; a pop in the same
  // cycle does not free a slot until the next cycle.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, rvalid_q};
  assign issue     = fetch_en_i & ~branch_i & (occupancy < DEPTH_LIMIT);

  // Gated by rst_n so the request drops the moment reset is asserted.
  assign mem_req_o  = issue & rst_n;
  assign mem_addr_o = pc[MEM_ADDR_WIDTH+INSTR_ALIGN_BITS-1:INSTR_ALIGN_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= BOOT_ADDR;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (branch_i) begin
      // Any read in flight belongs to the old stream and is discarded.
      pc       <= {branch_addr_i[ADDR_WIDTH-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
      rvalid_q <= 1'b0;
    end else if (issue) begin
      pc       <= pc + ADDR_WIDTH'(INSTR_BYTES);
      raddr_q  <= pc;
      rvalid_q <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
    end
  end

  assign push             = rvalid_q & ~branch_i;
  assign push_entry.addr  = raddr_q;
  assign push_entry.instr = mem_rdata_i;

  assign instr_valid_o = (count != '0) & ~branch_i;
  assign pop           = instr_valid_o & instr_ready_i;

  fetch_fifo #(
    .entry_t (fetch_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head_entry)
  );

  assign instr_rdata_o = head_entry.instr;
  assign instr_addr_o  = head_entry.addr;

endmodule

// File: doc/instr_prefetch_buf.md
Name: instr_prefetch_buf

Overview:
Instruction fetch/prefetch stage that sits downstream of the instruction RAM's single-port memory interface and upstream of the core's instruction decode. It owns the fetch PC and issues sequential word reads to the SRAM port, which has fixed 1-cycle read latency and no grant. Returned words are buffered with their addresses in a small FIFO and presented to the core through a valid/ready handshake. Branches flush the buffer and discard any in-flight read.

Parameters:
ADDR_WIDTH, 32, width of the byte-address PC and the instr_addr_o / branch_addr_i ports
DATA_WIDTH, 32, instruction word width; fixed at 32
MEM_ADDR_WIDTH, 14, word-address width of the instruction RAM port (65536 B / 4)
FIFO_DEPTH, 4, prefetch buffer entries; power of two, >= 2
BOOT_ADDR, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
fetch_en_i  input  1  fetch enable; low stops new memory requests
branch_i  input  1  redirect strobe, single cycle
branch_addr_i  input  ADDR_WIDTH  redirect target byte address
mem_req_o  output  1  RAM read enable; always accepted
mem_addr_o  output  MEM_ADDR_WIDTH  RAM word address, pc[MEM_ADDR_WIDTH+1:2]
mem_rdata_i  input  DATA_WIDTH  RAM read data, valid the cycle after mem_req_o
instr_valid_o  output  1  FIFO head valid
instr_ready_i  input  1  core accepts the head word
instr_rdata_o  output  DATA_WIDTH  head instruction
instr_addr_o  output  ADDR_WIDTH  head instruction byte address

Behaviour:
- Reset (async, rst_n low): pc=BOOT_ADDR, FIFO empty, count=0, rvalid_q=0, mem_req_o=0, instr_valid_o=0, mem_addr_o = BOOT_ADDR word index. instr_rdata_o and instr_addr_o are don't-care while instr_valid_o=0.
- Issue: mem_req_o = fetch_en_i & !branch_i & (count + rvalid_q < FIFO_DEPTH). This is a combinational output. Same-cycle pops are not credited.
- On issue: pc <= pc+4, rvalid_q <= 1, raddr_q <= pc. Otherwise rvalid_q <= 0. The PC wraps modulo 2^ADDR_WIDTH. Address bits above MEM_ADDR_WIDTH+1 are ignored on the RAM port.
- Response: while rvalid_q=1 and branch_i=0, push {raddr_q, mem_rdata_i} into the FIFO at the end of the cycle. The push never overflows, guaranteed by the issue condition.
- Output: instr_valid_o = (count != 0) & !branch_i. A pop occurs on instr_valid_o & instr_ready_i. Push and pop in the same cycle keep count unchanged.
- Branch (branch_i=1 in cycle T):
  - FIFO is cleared, rvalid_q is cleared (in-flight data dropped), no request is issued in T.
  - pc <= {branch_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - First request in T+1, RAM data in T+2, instr_valid_o in T+3 with instr_addr_o = aligned target.
  - A branch overrides any push or pop in the same cycle.
- fetch_en_i low: no new requests. An in-flight response still lands. The FIFO drains normally.
- Throughput: with instr_ready_i held high and fetch_en_i high, steady state is one instruction per cycle. Startup latency from reset release is 2 cycles (request in cycle 0, valid in cycle 2).
- FIFO: circular buffer with wrapping read/write pointers of width $clog2(FIFO_DEPTH) and a count of width $clog2(FIFO_DEPTH)+1. Head data are read combinationally from storage (no output register).

Decomposition:
- Package instr_fetch_pkg:
  - typedef fetch_entry_t (struct: addr[ADDR_WIDTH], instr[DATA_WIDTH]).
  - constants INSTR_BYTES=4 and INSTR_ALIGN_BITS=2.
- Sub-module fetch_fifo:
  - Parameterised on entry type and depth.
  - Ports: push/pop/flush, count, head data.
  - Flush has priority over push and pop.
- The top level holds the PC, the rvalid_q/raddr_q pipeline register and the issue logic.

Test Plan:
- Reset release with fetch_en_i=1, instr_ready_i=1, RAM preloaded with word n = 0x1000_0000+n → mem_addr_o 0,1,2,… on consecutive cycles. instr_valid_o rises 2 cycles after the first req. Outputs (addr,instr) are (0x0,0x10000000), (0x4,0x10000001), … one per cycle.
- instr_ready_i=0 from reset → exactly 4 requests are issued (addresses 0x0–0xC), then mem_req_o stays low. count=4. Raising ready pops 0x0,0x4,0x8,0xC in order, and requests resume at 0x10.
- branch_i with branch_addr_i=0x0000_0106 while the FIFO holds 3 entries and a read is in flight → instr_valid_o is low in T and the FIFO empties. mem_addr_o=0x41 in T+1. The first output in T+3 is addr 0x104. No stale word (pre-branch addresses) ever appears.
- Back-to-back branches to 0x200 then 0x300 → only 0x300-stream instructions are delivered, starting 3 cycles after the second branch.
- Drop fetch_en_i mid-stream with one read in flight → that word is still delivered and no further mem_req_o occurs. Re-enabling resumes at the next sequential address.
- Assert rst_n low while the FIFO is full and a read is in flight → instr_valid_o=0 and mem_req_o=0 immediately (asynchronous). After release, fetch restarts at BOOT_ADDR.
